fetch_stage: RTL and testbench

//  IF stage upstream of br_predictor and of the IF/ID boundary. Owns the fetch PC.

---
 rtl/fetch_stage.sv | 176 +++++++++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with one outstanding imem request, a
// one-entry skid buffer behind the IF/ID register, and execute redirect.
//
// state | meaning
// ------+---------------------------------------------------------------
// BOOT  | first cycle after reset, no request issued
// FETCH | request at pc outstanding, waiting for ack
// HOLD  | decode stalled with a word in flight; word parked in skid buffer
// DRAIN | redirect arrived mid-request; finish handshake, discard response
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pred_instr_o,
  output logic [31:0] pred_pc_o,
  input  logic        br_pred_i,
  input  logic [31:0] new_pc_pred_i,
  input  logic        miss_pred_i,
  input  logic [31:0] correct_pc_i,
  input  logic        stall_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic        if_br_pred_o,
  output logic [31:0] if_pred_pc_o
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        br_pred;
    logic [31:0] pred_pc;
  } entry_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  entry_t      skid_q, skid_d;
  entry_t      ifid_q, ifid_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        accept;
  logic        ack;
  entry_t      fetch_entry;

  // Request side is a pure function of state so reset drops it immediately.
  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = 32'h0000_0000;
    case (state_q)
      ST_FETCH: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_q;
      end
      ST_DRAIN: begin
        imem_req_o  = 1'b1;
        imem_addr_o = drain_addr_q;
      end
      default: begin
        imem_req_o  = 1'b0;
        imem_addr_o = 32'h0000_0000;
      end
    endcase
  end

  assign pred_instr_o = imem_rdata_i;
  assign pred_pc_o    = imem_addr_o;

  assign if_valid_o   = ifid_valid_q;
  assign if_instr_o   = ifid_q.instr;
  assign if_pc_o      = ifid_q.pc;
  assign if_br_pred_o = ifid_q.br_pred;
  assign if_pred_pc_o = ifid_q.pred_pc;

  // Next-state, pc, skid and IF/ID load decisions; redirect overrides all.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    skid_d       = skid_q;
    ifid_d       = ifid_q;
    ifid_valid_d = ifid_valid_q;

    accept      = !ifid_valid_q || !stall_i;
    // An ack without a live request carries no data and is ignored.
    ack         = imem_ack_i && imem_req_o;
    fetch_entry = '{instr:   imem_rdata_i,
                    pc:      imem_addr_o,
                    br_pred: br_pred_i,
                    pred_pc: new_pc_pred_i};

    if (miss_pred_i) begin
      ifid_valid_d = 1'b0;
      skid_d       = '0;
      pc_d         = correct_pc_i & ~32'd3;
      if (state_q == ST_FETCH && !ack) begin
        // Address must stay on the bus until the memory answers.
        state_d      = ST_DRAIN;
        drain_addr_d = pc_q;
      end else if (state_q == ST_DRAIN && !ack) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      if (accept) begin
        ifid_valid_d = 1'b0;
      end
      case (state_q)
        ST_BOOT: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (ack) begin
            pc_d = new_pc_pred_i & ~32'd3;
            if (accept) begin
              ifid_d       = fetch_entry;
              ifid_valid_d = 1'b1;
            end else begin
              skid_d  = fetch_entry;
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (accept) begin
            ifid_d       = skid_q;
            ifid_valid_d = 1'b1;
            skid_d       = '0;
            state_d      = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (ack) begin
            state_d = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'h0000_0000;
      skid_q       <= '0;
      ifid_q       <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      skid_q       <= skid_d;
      ifid_q       <= ifid_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small imem and branch predictor model.
module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pred_instr;
  logic [31:0] pred_pc;
  logic        br_pred;
  logic [31:0] new_pc_pred;
  logic        miss_pred;
  logic [31:0] correct_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_br_pred;
  logic [31:0] if_pred_pc;

  logic        ack_on;
  logic        force_ack;
  int          ack_delay;
  int          wait_cnt;
  logic [31:0] bimm;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .pred_instr_o  (pred_instr),
    .pred_pc_o     (pred_pc),
    .br_pred_i     (br_pred),
    .new_pc_pred_i (new_pc_pred),
    .miss_pred_i   (miss_pred),
    .correct_pc_i  (correct_pc),
    .stall_i       (stall),
    .if_valid_o    (if_valid),
    .if_instr_o    (if_instr),
    .if_pc_o       (if_pc),
    .if_br_pred_o  (if_br_pred),
    .if_pred_pc_o  (if_pred_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address 0x10 holds BEQ x0,x0,+0x20; everything else is addi x0,x0,addr[11:0].
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0200_0063;
    return {a[11:0], 20'h00013};
  endfunction

  always_comb begin
    imem_rdata = 32'h0;
    if (imem_req) imem_rdata = mem_word(imem_addr);
  end

  // Predictor model: every B-type predicted taken, else pc+4.
  assign bimm        = {{20{pred_instr[31]}}, pred_instr[7], pred_instr[30:25], pred_instr[11:8], 1'b0};
  assign br_pred     = (pred_instr[6:0] == 7'h63);
  assign new_pc_pred = br_pred ? pred_pc + bimm : pred_pc + 32'd4;

  assign imem_ack = force_ack | (ack_on & imem_req & (wait_cnt >= ack_delay));

  always @(posedge clk) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) tick;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    checks++; if ({if_instr, if_pc, if_pred_pc, if_br_pred} !== 97'h0) begin errors++; $display("FAIL reset_ifid: got %h/%h/%h/%b expected zeros", if_instr, if_pc, if_pred_pc, if_br_pred); end
    checks++; if (pred_instr !== 32'h0) begin errors++; $display("FAIL reset_pred_instr: got %h expected 0", pred_instr); end
    reset_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b expected 0", imem_req); end
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req: got %b/%h expected 1/00000000", imem_req, imem_addr); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL midreq_reset: got req %b valid %b expected 0/0", imem_req, if_valid); end
    tick;
    reset_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reboot_req: got %b expected 0", imem_req); end
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL refetch_req: got %b/%h expected 1/00000000", imem_req, imem_addr); end
  endtask

  task automatic test_sequential;
    ack_on = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr[%0d]: got %b/%h expected 1/%h", i, imem_req, imem_addr, 32'(4 * i)); end
      tick;
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_ifpc[%0d]: got %b/%h expected 1/%h", i, if_valid, if_pc, 32'(4 * i)); end
      checks++; if (if_instr !== mem_word(32'(4 * i)) || if_br_pred !== 1'b0 || if_pred_pc !== 32'(4 * i + 4)) begin errors++; $display("FAIL seq_entry[%0d]: got %h/%b/%h expected %h/0/%h", i, if_instr, if_br_pred, if_pred_pc, mem_word(32'(4 * i)), 32'(4 * i + 4)); end
    end
  endtask

  task automatic test_branch;
    checks++; if (imem_addr !== 32'h10 || pred_instr !== 32'h0200_0063 || pred_pc !== 32'h10) begin errors++; $display("FAIL br_fetch: got %h/%h/%h expected 00000010/02000063/00000010", imem_addr, pred_instr, pred_pc); end
    tick;
    checks++; if (if_br_pred !== 1'b1 || if_pred_pc !== 32'h30 || if_pc !== 32'h10) begin errors++; $display("FAIL br_entry: got %b/%h/%h expected 1/00000030/00000010", if_br_pred, if_pred_pc, if_pc); end
    checks++; if (imem_addr !== 32'h30) begin errors++; $display("FAIL br_target: got %h expected 00000030", imem_addr); end
  endtask

  task automatic test_stall_skid;
    bit          stall_pat [8] = '{0, 1, 1, 1, 0, 0, 0, 0};
    bit          req_pat   [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    logic [31:0] addr_pat  [8] = '{32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h8, 32'hC, 32'h10};
    logic [31:0] exp_pc;
    int          consumed;
    miss_pred  = 1'b1;
    correct_pc = 32'h0;
    #1;
    tick;
    miss_pred = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL redirect0: got %b/%h expected 0/00000000", if_valid, imem_addr); end
    exp_pc   = 32'h0;
    consumed = 0;
    for (int c = 0; c < 8; c++) begin
      stall = stall_pat[c];
      #1;
      checks++; if (imem_req !== req_pat[c]) begin errors++; $display("FAIL skid_req[%0d]: got %b expected %b", c, imem_req, req_pat[c]); end
      if (req_pat[c]) begin
        checks++; if (imem_addr !== addr_pat[c]) begin errors++; $display("FAIL skid_addr[%0d]: got %h expected %h", c, imem_addr, addr_pat[c]); end
      end
      if (if_valid && !stall) begin
        checks++; if (if_pc !== exp_pc) begin errors++; $display("FAIL skid_order[%0d]: got %h expected %h", c, if_pc, exp_pc); end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      tick;
    end
    checks++; if (consumed !== 4) begin errors++; $display("FAIL skid_count: got %0d expected 4", consumed); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h10) begin errors++; $display("FAIL skid_after: got %b/%h expected 1/00000010", if_valid, if_pc); end
  endtask

  task automatic test_drain;
    ack_delay = 2;
    #1;
    checks++; if (imem_addr !== 32'h30 || imem_ack !== 1'b0) begin errors++; $display("FAIL drain_start: got %h/%b expected 00000030/0", imem_addr, imem_ack); end
    tick;
    miss_pred  = 1'b1;
    correct_pc = 32'h100;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h30) begin errors++; $display("FAIL drain_hold1: got %b/%h expected 1/00000030", imem_req, imem_addr); end
    tick;
    miss_pred = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h30 || if_valid !== 1'b0) begin errors++; $display("FAIL drain_hold2: got %b/%h/%b expected 1/00000030/0", imem_req, imem_addr, if_valid); end
    tick;
    checks++; if (imem_addr !== 32'h100 || if_valid !== 1'b0) begin errors++; $display("FAIL drain_restart: got %h/%b expected 00000100/0", imem_addr, if_valid); end
    tick;
    tick;
    checks++; if (imem_ack !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL drain_wait: got ack %b valid %b addr %h expected 1/0/00000100", imem_ack, if_valid, imem_addr); end
    tick;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== mem_word(32'h100)) begin errors++; $display("FAIL drain_first: got %b/%h/%h expected 1/00000100/%h", if_valid, if_pc, if_instr, mem_word(32'h100)); end
    ack_delay = 0;
  endtask

  task automatic test_flush_priority;
    stall = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin errors++; $display("FAIL fl_pre: got %b/%h expected 1/00000104", imem_req, imem_addr); end
    tick;
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h100) begin errors++; $display("FAIL fl_hold: got %b/%b/%h expected 0/1/00000100", imem_req, if_valid, if_pc); end
    miss_pred  = 1'b1;
    correct_pc = 32'h203;
    force_ack  = 1'b1;
    #1;
    tick;
    miss_pred = 1'b0;
    force_ack = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL fl_flush: got %b/%b/%h expected 0/1/00000200", if_valid, imem_req, imem_addr); end
    tick;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== mem_word(32'h200)) begin errors++; $display("FAIL fl_next: got %b/%h/%h expected 1/00000200/%h", if_valid, if_pc, if_instr, mem_word(32'h200)); end
    stall = 1'b0;
    #1;
    tick;
    checks++; if (if_pc !== 32'h204) begin errors++; $display("FAIL fl_follow: got %h expected 00000204", if_pc); end
  endtask

  task automatic test_wrap;
    miss_pred  = 1'b1;
    correct_pc = 32'hFFFF_FFFC;
    #1;
    tick;
    miss_pred = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_addr); end
    tick;
    checks++; if (if_pc !== 32'hFFFF_FFFC || if_pred_pc !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h/%h/%h expected fffffffc/00000000/00000000", if_pc, if_pred_pc, imem_addr); end
  endtask

  task automatic test_async_reset;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || if_pc !== 32'h0) begin errors++; $display("FAIL areset: got %b/%b/%h expected 0/0/00000000", if_valid, imem_req, if_pc); end
    tick;
    reset_n = 1'b1;
    #1;
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL areset_restart: got %b/%h expected 1/00000000", imem_req, imem_addr); end
  endtask

  initial begin
    reset_n    = 1'b0;
    ack_on     = 1'b0;
    force_ack  = 1'b0;
    ack_delay  = 0;
    wait_cnt   = 0;
    miss_pred  = 1'b0;
    correct_pc = 32'h0;
    stall      = 1'b0;
    test_reset;
    test_sequential;
    test_branch;
    test_stall_skid;
    test_drain;
    test_flush_priority;
    test_wrap;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
